// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath and its sample feeder.
// Defaults here are shared with the time-shared 3-tap FIR.
package fir_pkg;

    localparam int DATA_W      = 8;
    localparam int SLOT_CYCLES = 4;

    localparam logic [1:0] CFG_A = 2'd0;
    localparam logic [1:0] CFG_B = 2'd1;
    localparam logic [1:0] CFG_C = 2'd2;

endpackage

// File: rtl/fir_feed_fifo.sv
// Small synchronous FIFO with occupancy count.
// Read data is the combinational head entry.
module fir_feed_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// Slot-aligned sample feeder and double-buffered coefficients
// for the time-shared 3-tap FIR.
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int DATA_W      = fir_pkg::DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int SLOT_CYCLES = fir_pkg::SLOT_CYCLES,
    parameter int LVL_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    output logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] coeffA,
    output logic [DATA_W-1:0] coeffB,
    output logic [DATA_W-1:0] coeffC,
    output logic              slot_start,
    output logic              sample_valid,
    output logic              underrun,
    output logic [LVL_W-1:0]  level
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT_CYCLES - 1);

    logic [CNT_W-1:0]  slot_cnt;
    logic              upd;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] sh_a;
    logic [DATA_W-1:0] sh_b;
    logic [DATA_W-1:0] sh_c;

    assign upd        = (slot_cnt == LAST);
    assign slot_start = (slot_cnt == '0);
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    // Pop sees the pre-edge level, so a push on the update edge never bypasses.
    assign pop        = upd && !empty;

    fir_feed_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt     <= '0;
            datain       <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
            coeffA       <= '0;
            coeffB       <= '0;
            coeffC       <= '0;
        end else begin
            slot_cnt <= upd ? '0 : slot_cnt + CNT_W'(1);
            underrun <= 1'b0;
            if (upd) begin
                datain       <= empty ? '0 : head;
                sample_valid <= !empty;
                underrun     <= empty;
                coeffA       <= sh_a;
                coeffB       <= sh_b;
                coeffC       <= sh_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a <= '0;
            sh_b <= '0;
            sh_c <= '0;
        end else if (cfg_we) begin
            unique case (1'b1)
                cfg_addr == CFG_A: sh_a <= cfg_data;
                cfg_addr == CFG_B: sh_b <= cfg_data;
                cfg_addr == CFG_C: sh_c <= cfg_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Scoreboard bench for fir_sample_feeder: queue-level reference
// model feeds expected slots, a negedge monitor checks them.
module tb_fir_sample_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SC    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic [DW-1:0] datain;
    logic [DW-1:0] coeffA;
    logic [DW-1:0] coeffB;
    logic [DW-1:0] coeffC;
    logic          slot_start;
    logic          sample_valid;
    logic          underrun;
    logic [2:0]    level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int d;
        int v;
        int u;
        int a;
        int b;
        int c;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    exp_t e;
    int   mq[$];
    int   mcnt;
    int   msh[3];
    int   mact[3];
    bit   mrdy;

    fir_sample_feeder #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .SLOT_CYCLES (SC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .datain       (datain),
        .coeffA       (coeffA),
        .coeffB       (coeffB),
        .coeffC       (coeffC),
        .slot_start   (slot_start),
        .sample_valid (sample_valid),
        .underrun     (underrun),
        .level        (level)
    );

    always #5 clk = ~clk;

    // Reference: a byte queue, a free-running slot index and coefficient arrays.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            mcnt = 0;
            msh  = '{0, 0, 0};
            mact = '{0, 0, 0};
            exp_q.push_back('{0, 0, 0, 0, 0, 0});
        end else begin
            mrdy = mq.size() < DEPTH;
            if (mcnt == SC - 1) begin
                if (mq.size() > 0) begin
                    e.d = mq.pop_front();
                    e.v = 1;
                    e.u = 0;
                end else begin
                    e.d = 0;
                    e.v = 0;
                    e.u = 1;
                end
                mact = msh;
                e.a = mact[0];
                e.b = mact[1];
                e.c = mact[2];
                exp_q.push_back(e);
            end
            if (in_valid && mrdy) mq.push_back(int'(in_data));
            if (cfg_we && cfg_addr != 2'd3) msh[cfg_addr] = int'(cfg_data);
            mcnt = (mcnt + 1) % SC;
        end
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h want %0h", n, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (slot_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty t=%0t got 0 want 1", $time);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            chk("slot_start", 32'(slot_start), 32'(mcnt == 0));
            chk("level", 32'(level), 32'(mq.size()));
            chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("datain", 32'(datain), cur.d);
            chk("sample_valid", 32'(sample_valid), cur.v);
            chk("underrun", 32'(underrun), slot_start ? cur.u : 0);
            chk("coeffA", 32'(coeffA), cur.a);
            chk("coeffB", 32'(coeffB), cur.b);
            chk("coeffC", 32'(coeffC), cur.c);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic wait_cnt(int c);
        for (int k = 0; k < 2 * SC && mcnt != c; k++) tick();
    endtask

    task automatic send(logic [DW-1:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 64 && !ok; k++) begin
            ok = in_ready;
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got 0 want 1");
        end
    endtask

    task automatic cfg(logic [1:0] a, logic [DW-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    int p;

    initial begin
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        send(8'h11);
        send(8'h22);
        send(8'h33);
        in_valid = 1'b0;
        idle(4 * SC);

        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i));
        in_valid = 1'b0;
        idle(8 * SC);

        wait_cnt(SC - 1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        idle(2 * SC);

        wait_cnt(1);
        cfg(2'd0, 8'h03);
        cfg(2'd2, 8'h44);
        wait_cnt(SC - 1);
        cfg(2'd1, 8'h07);
        cfg(2'd3, 8'hFF);
        idle(3 * SC);

        wait_cnt(SC - 1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h61 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(2 * SC);

        p = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) p = $urandom_range(5, 100);
            in_valid = ($urandom_range(0, 99) < p);
            in_data  = DW'($urandom);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_data = DW'($urandom);
            rst      = ($urandom_range(0, 499) == 0);
            tick();
        end
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        rst      = 1'b0;
        idle(3 * SC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
